bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 16 +
 rtl/bit_serializer.sv | 106 ++++++++++
 tb/tb_bit_serializer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serializer and the sequence-detector blocks that
// consume its bit stream.
package bit_serializer_pkg;

  // Default maximum word length in bits.
  localparam int DEFAULT_WIDTH = 16;

  // Serializer FSM state encoding, kept as plain constants so older blocks
  // that compare raw state codes keep working.
  typedef logic [1:0] ser_state_t;

  localparam ser_state_t ST_IDLE  = 2'd0;
  localparam ser_state_t ST_SHIFT = 2'd1;
  localparam ser_state_t ST_LAST  = 2'd2;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer.sv
// MSB-first word serializer. A word of 1..WIDTH bits is captured left-aligned
// and shifted out one bit per enabled cycle. Back-to-back words run without a
// gap: a new load is accepted in the cycle that presents the last bit.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH):0]   len,
  input  logic                     en,
  output logic                     ready,
  output logic                     in_bit,
  output logic                     bit_valid,
  output logic                     done,
  output logic                     err
);

  localparam int LW = $clog2(WIDTH) + 1;
  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LW-1:0]    cnt_q,   cnt_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;

  logic len_ok;
  logic accept;
  logic reject;
  logic consume;

  // Handshake decode: a load is only looked at while ready is high.
  always_comb begin
    len_ok  = (len != '0) && (len <= WIDTH_L);
    accept  = load && ready && len_ok;
    reject  = load && ready && !len_ok;
    consume = en && (state_q != ST_IDLE);
  end

  // Next-state logic for the FSM, shift register and remaining-bit counter.
  always_comb begin
    // NOTE: every target gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = reject;

    if (accept) begin
      // Left-align so data[len-1] lands in the MSB; bits above len-1 fall off.
      shreg_d = data << (WIDTH_L - len);
      cnt_d   = len;
      state_d = (len == LW'(1)) ? ST_LAST : ST_SHIFT;
      // A load taken in LAST replaces the final bit, so that bit is consumed
      // on this edge and the word still completes.
      done_d  = (state_q == ST_LAST);
    end else if (consume) begin
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - LW'(1);
      case (state_q)
        ST_SHIFT: if (cnt_q == LW'(2)) state_d = ST_LAST;
        ST_LAST: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    // NOTE: the shift register and counter are reset too, because in_bit and
    // the count must read as zero straight out of reset.
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed before this edge, independent of statement order.
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Output decode: the serial bit is forced low whenever no payload is present.
  always_comb begin
    ready     = (state_q == ST_IDLE) || (state_q == ST_LAST);
    bit_valid = (state_q != ST_IDLE);
    in_bit    = bit_valid && shreg_q[WIDTH-1];
    done      = done_q;
    err       = err_q;
  end

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer with hand-computed expected streams.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;
  localparam int LW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] data;
  logic [LW-1:0]    len;
  logic             en;
  logic             ready;
  logic             in_bit;
  logic             bit_valid;
  logic             done;
  logic             err;

  int total = 0;
  int bad   = 0;

  // Expected streams, MSB first.
  logic [8:0]  w9      = 9'b111011011;            // 0x01DB, len 9
  logic [18:0] w19     = 19'b1011011011111011011; // 0x2DB/10 then 0x01DB/9
  logic [8:0]  exp_hit = 9'b100100000;            // "1011" ends at bits 5 and 8
  logic [15:0] w16     = 16'h8001;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (data),
    .len       (len),
    .en        (en),
    .ready     (ready),
    .in_bit    (in_bit),
    .bit_valid (bit_valid),
    .done      (done),
    .err       (err)
  );

  // Small overlapping "1011" detector fed by the serial stream.
  logic [2:0] hist_q;
  logic       det_hit;

  always_ff @(posedge clk) begin
    if (rst) hist_q <= '0;
    else if (bit_valid && en) hist_q <= {hist_q[1:0], in_bit};
  end

  assign det_hit = bit_valid && ({hist_q, in_bit} == 4'b1011);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dones;
    int idx;

    rst = 1'b1; load = 1'b0; data = '0; len = '0; en = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_ready", 32'(ready),     32'd1);
    check("rst_valid", 32'(bit_valid), 32'd0);
    check("rst_bit",   32'(in_bit),    32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);

    // Single 9-bit word; a load during SHIFT is ignored.
    load = 1'b1; data = 16'h01DB; len = LW'(9);
    step();
    load = 1'b0; data = 16'hFFFF; len = LW'(3);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t1_bit%0d", i), 32'(in_bit), 32'(w9[8-i]));
      check("t1_valid", 32'(bit_valid), 32'd1);
      check("t1_done_low", 32'(done), 32'd0);
      if (i == 0) check("t1_ready_shift", 32'(ready), 32'd0);
      if (i == 8) check("t1_ready_last",  32'(ready), 32'd1);
      if (i == 2) load = 1'b1;
      step();
      load = 1'b0;
      if (i == 2) check("t1_no_err", 32'(err), 32'd0);
    end
    check("t1_done",      32'(done),      32'd1);
    check("t1_idle_val",  32'(bit_valid), 32'd0);
    check("t1_idle_bit",  32'(in_bit),    32'd0);
    check("t1_idle_rdy",  32'(ready),     32'd1);
    step();
    check("t1_done_end",  32'(done),      32'd0);

    // Back-to-back words, second load in the LAST cycle of the first.
    load = 1'b1; data = 16'h02DB; len = LW'(10);
    step();
    load = 1'b0;
    dones = 0;
    for (int i = 0; i < 19; i++) begin
      check($sformatf("t2_bit%0d", i), 32'(in_bit), 32'(w19[18-i]));
      check("t2_valid", 32'(bit_valid), 32'd1);
      if (done) dones++;
      if (i == 10) check("t2_done_overlap", 32'(done), 32'd1);
      if (i == 9) begin
        load = 1'b1; data = 16'h01DB; len = LW'(9);
      end
      step();
      load = 1'b0;
    end
    check("t2_done2", 32'(done), 32'd1);
    if (done) dones++;
    check("t2_done_count", 32'(dones), 32'd2);
    check("t2_idle_val", 32'(bit_valid), 32'd0);
    step();

    // en low for 3 cycles while the 4th bit is shown.
    load = 1'b1; data = 16'h01DB; len = LW'(9);
    step();
    load = 1'b0;
    for (int c = 0; c < 12; c++) begin
      idx = (c <= 6) ? ((c < 3) ? c : 3) : c - 3;
      check($sformatf("t3_cyc%0d", c), 32'(in_bit), 32'(w9[8-idx]));
      check("t3_valid", 32'(bit_valid), 32'd1);
      check("t3_done_low", 32'(done), 32'd0);
      en = !(c >= 3 && c <= 5);
      step();
      en = 1'b1;
    end
    check("t3_done", 32'(done), 32'd1);
    check("t3_idle", 32'(bit_valid), 32'd0);
    step();

    // Illegal lengths are rejected with an err pulse.
    for (int k = 0; k < 2; k++) begin
      load = 1'b1; data = 16'hABCD; len = (k == 0) ? LW'(0) : LW'(WIDTH + 1);
      step();
      load = 1'b0;
      check($sformatf("t4_err%0d", k),   32'(err),       32'd1);
      check($sformatf("t4_ready%0d", k), 32'(ready),     32'd1);
      check($sformatf("t4_valid%0d", k), 32'(bit_valid), 32'd0);
      step();
      check($sformatf("t4_err_end%0d", k), 32'(err),       32'd0);
      check($sformatf("t4_idle%0d", k),    32'(bit_valid), 32'd0);
    end

    // Full-width word.
    load = 1'b1; data = w16; len = LW'(WIDTH);
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_w16_bit%0d", i), 32'(in_bit), 32'(w16[15-i]));
      step();
    end
    check("t4_w16_done", 32'(done), 32'd1);

    // Single-bit word: goes straight to LAST, only data[0] matters.
    load = 1'b1; data = 16'hFFFE; len = LW'(1);
    step();
    load = 1'b0;
    check("t4_len1_bit",   32'(in_bit),    32'd0);
    check("t4_len1_valid", 32'(bit_valid), 32'd1);
    check("t4_len1_ready", 32'(ready),     32'd1);
    step();
    check("t4_len1_done",  32'(done),      32'd1);
    check("t4_len1_idle",  32'(bit_valid), 32'd0);
    step();

    // Reset on the 5th bit aborts the word without a done pulse.
    load = 1'b1; data = 16'h01DB; len = LW'(9);
    step();
    load = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("t5_bit5", 32'(in_bit), 32'(w9[4]));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", 32'(bit_valid), 32'd0);
    check("t5_ready", 32'(ready),     32'd1);
    check("t5_done",  32'(done),      32'd0);
    check("t5_bit",   32'(in_bit),    32'd0);
    step();
    check("t5_done_after", 32'(done), 32'd0);

    // Chain into the "1011" detector.
    load = 1'b1; data = 16'h01DB; len = LW'(9);
    step();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t6_hit%0d", i), 32'(det_hit), 32'(exp_hit[i]));
      step();
    end
    check("t6_done", 32'(done), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bit_serializer
